// File: rtl/prbs16_checker.sv
// Receive-side checker for the x^16+x^14+x^13+x^11+1 PRBS: self-syncs, locks, counts bit errors.
// Optional PRBS_CHK_CLR_EN adds clr_cnt, a synchronous clear of err_count/bit_count.
module prbs16_checker #(
   parameter int LOCK_CNT    = 16,
   parameter int WIN_LEN     = 256,
   parameter int LOSS_THRESH = 16,
   parameter int CNT_W       = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             rx_valid,
   input  logic             rx_bit,
`ifdef PRBS_CHK_CLR_EN
   input  logic             clr_cnt,
`endif
   output logic             locked,
   output logic             err_pulse,
   output logic [CNT_W-1:0] err_count,
   output logic [CNT_W-1:0] bit_count
);

   localparam int VER_W = $clog2(LOCK_CNT + 1);
   localparam int WIN_W = $clog2(WIN_LEN);
   localparam int WE_W  = $clog2(LOSS_THRESH + 1);

   localparam logic [VER_W-1:0] VER_LAST = VER_W'(LOCK_CNT - 1);
   localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WIN_LEN - 1);
   localparam logic [WE_W-1:0]  WE_LIM   = WE_W'(LOSS_THRESH);

   typedef enum logic [1:0] {SEARCH, VERIFY, LOCKED} state_t;

   state_t           state, state_nx;
   logic [15:0]      sr, sr_nx;
   logic [3:0]       fill, fill_nx;
   logic [VER_W-1:0] ver, ver_nx;
   logic [WIN_W-1:0] win, win_nx;
   logic [WE_W-1:0]  werr, werr_nx, werr_sum;
   logic             pred, mismatch;
   logic             pulse_nx;
   logic [CNT_W-1:0] errc_nx, bitc_nx;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   assign pred     = sr[15] ^ sr[13] ^ sr[12] ^ sr[10];
   assign mismatch = rx_bit ^ pred;
   assign werr_sum = mismatch ? werr + 1'b1 : werr;

   always_comb begin
      state_nx = state;
      sr_nx    = sr;
      fill_nx  = fill;
      ver_nx   = ver;
      win_nx   = win;
      werr_nx  = werr;
      pulse_nx = 1'b0;
      errc_nx  = err_count;
      bitc_nx  = bit_count;

      if (rx_valid) begin
         case (state)
            SEARCH: begin
               sr_nx = {sr[14:0], rx_bit};
               if (fill == 4'd15) begin
                  fill_nx = '0;
                  // All-zero is the PRBS lock-up state; keep filling instead.
                  if (sr_nx != '0) begin
                     state_nx = VERIFY;
                     ver_nx   = '0;
                  end
               end else begin
                  fill_nx = fill + 1'b1;
               end
            end
            VERIFY: begin
               sr_nx = {sr[14:0], rx_bit};
               if (mismatch) begin
                  state_nx = SEARCH;
                  fill_nx  = '0;
               end else if (ver == VER_LAST) begin
                  state_nx = LOCKED;
                  win_nx   = '0;
                  werr_nx  = '0;
               end else begin
                  ver_nx = ver + 1'b1;
               end
            end
            LOCKED: begin
               // Reference free-runs on its own prediction so a flipped bit is one error.
               sr_nx   = {sr[14:0], pred};
               bitc_nx = sat_inc(bit_count);
               win_nx  = (win == WIN_LAST) ? '0 : win + 1'b1;
               if (mismatch) begin
                  pulse_nx = 1'b1;
                  errc_nx  = sat_inc(err_count);
               end
               if (werr_sum >= WE_LIM) begin
                  state_nx = SEARCH;
                  fill_nx  = '0;
                  win_nx   = '0;
                  werr_nx  = '0;
               end else if (win == WIN_LAST) begin
                  werr_nx = '0;
               end else begin
                  werr_nx = werr_sum;
               end
            end
            default: state_nx = SEARCH;
         endcase
      end

`ifdef PRBS_CHK_CLR_EN
      if (clr_cnt) begin
         errc_nx = '0;
         bitc_nx = '0;
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= SEARCH;
         sr        <= '0;
         fill      <= '0;
         ver       <= '0;
         win       <= '0;
         werr      <= '0;
         locked    <= 1'b0;
         err_pulse <= 1'b0;
         err_count <= '0;
         bit_count <= '0;
      end else begin
         state     <= state_nx;
         sr        <= sr_nx;
         fill      <= fill_nx;
         ver       <= ver_nx;
         win       <= win_nx;
         werr      <= werr_nx;
         locked    <= (state_nx == LOCKED);
         err_pulse <= pulse_nx;
         err_count <= errc_nx;
         bit_count <= bitc_nx;
      end
   end

endmodule

// File: tb/tb_prbs16_checker.sv
// Bench for prbs16_checker: table of error-injection scenarios plus gap/reset sequence.
module tb_prbs16_checker;
   localparam int CNT_W = 32;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             rx_valid = 1'b0;
   logic             rx_bit = 1'b0;
`ifdef PRBS_CHK_CLR_EN
   logic             clr_cnt = 1'b0;
`endif
   logic             locked, err_pulse;
   logic [CNT_W-1:0] err_count, bit_count;

   always #5 clk = ~clk;

   prbs16_checker #(.LOCK_CNT(16), .WIN_LEN(256), .LOSS_THRESH(16), .CNT_W(CNT_W)) dut (
      .clk      (clk),
      .rst      (rst),
      .rx_valid (rx_valid),
      .rx_bit   (rx_bit),
`ifdef PRBS_CHK_CLR_EN
      .clr_cnt  (clr_cnt),
`endif
      .locked   (locked),
      .err_pulse(err_pulse),
      .err_count(err_count),
      .bit_count(bit_count)
   );

   // Error windows are offsets counted from the first checked (locked) bit, i.e. stream bit 33.
   typedef struct {
      int n_bits;
      bit zero;
      int e1s, e1n, e2s, e2n;
      int loss_bit;
      bit exp_locked;
      int exp_err;
      int exp_bits;
   } vec_t;

   typedef struct {
      logic lk;
      logic ep;
   } exp_t;

   exp_t        exp_q[$];
   vec_t        tbl[5];
   int          checks = 0;
   int          errors = 0;
   logic [15:0] gen;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic gen_bit(output logic b);
      b   = gen[15] ^ gen[13] ^ gen[12] ^ gen[10];
      gen = {gen[14:0], b};
   endtask

   task automatic cycle(input logic v, input logic b, input logic el, input logic ep);
      exp_t e;
      rx_valid = v;
      rx_bit   = b;
      e.lk = el;
      e.ep = ep;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      chk("locked", {63'd0, locked}, {63'd0, e.lk});
      chk("err_pulse", {63'd0, err_pulse}, {63'd0, e.ep});
   endtask

   task automatic do_reset();
      rst      = 1'b1;
      rx_valid = 1'b1;
      rx_bit   = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      gen = 16'h0001;
      chk("rst_locked", {63'd0, locked}, 64'd0);
      chk("rst_err_pulse", {63'd0, err_pulse}, 64'd0);
      chk("rst_err_count", 64'(err_count), 64'd0);
      chk("rst_bit_count", 64'(bit_count), 64'd0);
   endtask

   initial begin
      int   vcnt;
      logic b, f;

      //          n     zero e1s e1n  e2s e2n loss lk err bits
      tbl[0] = '{1000, 1'b0, 0,  0,   0,  0,  0, 1'b1, 0,  968};
      tbl[1] = '{ 300, 1'b0, 50, 1,   0,  0,  0, 1'b1, 1,  268};
      tbl[2] = '{ 140, 1'b0, 10, 16,  0,  0, 58, 1'b1, 16,  76};
      tbl[3] = '{ 432, 1'b0, 10, 15, 266, 15, 0, 1'b1, 30, 400};
      tbl[4] = '{ 500, 1'b1, 0,  0,   0,  0,  0, 1'b0, 0,    0};

      for (int t = 0; t < 5; t++) begin
         do_reset();
         for (int i = 1; i <= tbl[t].n_bits; i++) begin
            int   o;
            logic fl, el;
            o = i - 33;
            if (tbl[t].zero) b = 1'b0;
            else gen_bit(b);
            fl = !tbl[t].zero && o >= 0 &&
                 ((o >= tbl[t].e1s && o < tbl[t].e1s + tbl[t].e1n) ||
                  (o >= tbl[t].e2s && o < tbl[t].e2s + tbl[t].e2n));
            el = !tbl[t].zero && i >= 32 &&
                 !(tbl[t].loss_bit != 0 && i >= tbl[t].loss_bit && i < tbl[t].loss_bit + 32);
            cycle(1'b1, b ^ fl, el, fl);
         end
         chk($sformatf("vec%0d_locked", t), {63'd0, locked}, {63'd0, tbl[t].exp_locked});
         chk($sformatf("vec%0d_err_count", t), 64'(err_count), 64'(tbl[t].exp_err));
         chk($sformatf("vec%0d_bit_count", t), 64'(bit_count), 64'(tbl[t].exp_bits));
      end

      // Valid every other cycle; one flip at valid bit 45 followed by an idle cycle.
      do_reset();
      vcnt = 0;
      for (int k = 0; k < 120; k++) begin
         if (k % 2 == 0) begin
            gen_bit(b);
            vcnt++;
            f = (vcnt == 45);
            cycle(1'b1, b ^ f, vcnt >= 32, f);
         end else begin
            cycle(1'b0, 1'($urandom_range(0, 1)), vcnt >= 32, 1'b0);
         end
      end
      chk("gap_err_count", 64'(err_count), 64'd1);
      chk("gap_bit_count", 64'(bit_count), 64'd28);

      // Reset mid-stream with a valid bit present, then relock on 32 further valid bits.
      rst = 1'b1;
      gen_bit(b);
      cycle(1'b1, b, 1'b0, 1'b0);
      rst = 1'b0;
      chk("midrst_err_count", 64'(err_count), 64'd0);
      chk("midrst_bit_count", 64'(bit_count), 64'd0);
      vcnt = 0;
      for (int k = 0; k < 80; k++) begin
         if (k % 2 == 0) begin
            gen_bit(b);
            vcnt++;
            cycle(1'b1, b, vcnt >= 32, 1'b0);
         end else begin
            cycle(1'b0, 1'($urandom_range(0, 1)), vcnt >= 32, 1'b0);
         end
      end
      chk("relock_err_count", 64'(err_count), 64'd0);
      chk("relock_bit_count", 64'(bit_count), 64'd8);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
